// File: rtl/cache_arbiter_pkg.sv
// Shared types and constants for the cache arbiter: FSM states, port IDs and
// the saturation limit used by the optional hit/miss statistics.
package cache_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CHECK,
    STALL,
    ACK
  } state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam logic [15:0] CNT_SAT = 16'hFFFF;

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == CNT_SAT) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/cache_arbiter_rr_arb2.sv
// Two-input round-robin picker: a lone request wins outright, a tie goes to
// the port that was not granted last. Purely combinational, one-hot grant.
module rr_arb2
  import cache_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || (last_gnt == PORT_B))) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Round-robin two-port sequencer in front of a write-through data cache.
// Optional hit/miss statistics are built when CACHE_ARBITER_STATS_EN is defined.
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 4
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              ReqA,
  input  logic              ReqB,
  input  logic              WriteA,
  input  logic              WriteB,
  input  logic [ADDR_W-1:0] AddrA,
  input  logic [ADDR_W-1:0] AddrB,
  input  logic [DATA_W-1:0] WDataA,
  input  logic [DATA_W-1:0] WDataB,
  output logic              AckA,
  output logic              AckB,
  output logic [DATA_W-1:0] RData,
  output logic              CacheStrobe,
  output logic [ADDR_W-1:0] CacheAddress,
  output logic              CacheWrite,
  output logic [DATA_W-1:0] CacheWriteData,
  input  logic              CacheHit,
  input  logic [DATA_W-1:0] CacheReadData,
  output logic [15:0]       HitCount,
  output logic [15:0]       MissCount
);

  localparam int CNT_W = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e              state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_q, last_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          gnt;

  rr_arb2 u_rr_arb2 (
    .req      ({ReqB, ReqA}),
    .last_gnt (last_q),
    .gnt      (gnt)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          grant_d = gnt[1] ? PORT_B : PORT_A;
          addr_d  = gnt[1] ? AddrB  : AddrA;
          write_d = gnt[1] ? WriteB : WriteA;
          wdata_d = gnt[1] ? WDataB : WDataA;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = CHECK;
      CHECK: begin
        rdata_d = CacheReadData;
        if (!write_q && CacheHit) begin
          state_d = ACK;
        end else begin
          // Write-through: every write, hit or miss, pays the memory latency.
          cnt_d   = LAT_LOAD;
          state_d = (MEM_LAT == 0) ? ACK : STALL;
        end
      end
      STALL: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q <= CNT_ONE) begin
          state_d = ACK;
        end
      end
      ACK: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      grant_q <= PORT_A;
      last_q  <= PORT_B;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign CacheStrobe    = (state_q == ISSUE);
  assign CacheAddress   = addr_q;
  assign CacheWrite     = write_q;
  assign CacheWriteData = wdata_q;
  assign RData          = rdata_q;
  assign AckA           = (state_q == ACK) && (grant_q == PORT_A);
  assign AckB           = (state_q == ACK) && (grant_q == PORT_B);

`ifdef CACHE_ARBITER_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == CHECK) begin
      if (CacheHit) begin
        hit_cnt_d = sat_inc(hit_cnt_q);
      end else begin
        miss_cnt_d = sat_inc(miss_cnt_q);
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign HitCount  = hit_cnt_q;
  assign MissCount = miss_cnt_q;
`else
  assign HitCount  = 16'd0;
  assign MissCount = 16'd0;
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: a behavioural cache/memory model predicts
// grant order, Ack cycle and read data; a monitor pops and compares on each Ack.
module tb_cache_arbiter;

  localparam int LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_a, req_b, wr_a, wr_b;
  logic [15:0] addr_a, addr_b, wd_a, wd_b;
  logic        ack_a, ack_b;
  logic [15:0] rdata;
  logic        c_strobe, c_wr;
  logic [15:0] c_addr, c_wd;
  logic        c_hit;
  logic [15:0] c_rd;
  logic [15:0] hit_cnt, miss_cnt;

  cache_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) u_dut (
    .Clock(clk), .Reset_n(rst_n),
    .ReqA(req_a), .ReqB(req_b), .WriteA(wr_a), .WriteB(wr_b),
    .AddrA(addr_a), .AddrB(addr_b), .WDataA(wd_a), .WDataB(wd_b),
    .AckA(ack_a), .AckB(ack_b), .RData(rdata),
    .CacheStrobe(c_strobe), .CacheAddress(c_addr), .CacheWrite(c_wr),
    .CacheWriteData(c_wd), .CacheHit(c_hit), .CacheReadData(c_rd),
    .HitCount(hit_cnt), .MissCount(miss_cnt)
  );

  // Second instance with zero memory latency against an always-miss cache.
  logic        z_req, z_wr, z_zero;
  logic [15:0] z_addr, z_wd, z_zero16, z_crd;
  logic        z_hit;
  logic        z_ack_a, z_ack_b, z_strobe, z_cwr;
  logic [15:0] z_rdata, z_caddr, z_cwd, z_hitc, z_missc;

  cache_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(0)) u_dut_z (
    .Clock(clk), .Reset_n(rst_n),
    .ReqA(z_req), .ReqB(z_zero), .WriteA(z_wr), .WriteB(z_zero),
    .AddrA(z_addr), .AddrB(z_zero16), .WDataA(z_wd), .WDataB(z_zero16),
    .AckA(z_ack_a), .AckB(z_ack_b), .RData(z_rdata),
    .CacheStrobe(z_strobe), .CacheAddress(z_caddr), .CacheWrite(z_cwr),
    .CacheWriteData(z_cwd), .CacheHit(z_hit), .CacheReadData(z_crd),
    .HitCount(z_hitc), .MissCount(z_missc)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        port;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  // Cache stub: 8-line direct-mapped, write-allocate, backed by 32-word memory.
  logic [15:0] s_mem [32];
  logic [12:0] s_tag [8];
  logic [15:0] s_data[8];

  always @(negedge clk) begin : stub
    logic [2:0] ix;
    if (c_strobe) begin
      ix = c_addr[2:0];
      if (c_wr) begin
        c_hit = (s_tag[ix] == c_addr[15:3]);
        s_mem[c_addr[4:0]] = c_wd;
        s_tag[ix]  = c_addr[15:3];
        s_data[ix] = c_wd;
        c_rd = c_wd;
      end else if (s_tag[ix] == c_addr[15:3]) begin
        c_hit = 1'b1;
        c_rd  = s_data[ix];
      end else begin
        c_hit = 1'b0;
        s_tag[ix]  = c_addr[15:3];
        s_data[ix] = s_mem[c_addr[4:0]];
        c_rd = s_data[ix];
      end
    end
  end

  // Reference model: which address each line holds, plus memory contents.
  int          m_res[8];
  logic [15:0] m_mem[32];
  int          m_hits, m_misses, m_last_ack;
  logic        m_last;

  function automatic int access(input logic wr, input logic [15:0] a,
                                input logic [15:0] wd, output logic [15:0] rd);
    logic hit;
    int ix;
    ix  = int'(a[2:0]);
    hit = (m_res[ix] == int'(a));
    rd  = m_mem[a[4:0]];
    if (hit) m_hits++; else m_misses++;
    if (wr) begin
      m_mem[a[4:0]] = wd;
      m_res[ix] = int'(a);
    end else if (!hit) begin
      m_res[ix] = int'(a);
    end
    return (wr || !hit) ? LAT : 0;
  endfunction

  function automatic int push_exp(input logic port, input logic wr, input logic [15:0] a,
                                  input logic [15:0] wd, input int start);
    exp_t e;
    int st, stall;
    logic [15:0] rd;
    st = (start > m_last_ack) ? start : m_last_ack + 1;
    stall = access(wr, a, wd, rd);
    e.port = port; e.wr = wr; e.addr = a; e.wdata = wd; e.rdata = rd;
    e.cyc = st + 3 + stall;
    exp_q.push_back(e);
    m_last = port;
    m_last_ack = e.cyc;
    return e.cyc;
  endfunction

  logic strobe_prev = 1'b0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (ack_a || ack_b) begin
        checks++;
        if (ack_a && ack_b) begin
          errors++; $display("FAIL ack_exclusive: AckA=%b AckB=%b, required one-hot", ack_a, ack_b);
        end
      end
      if (c_strobe) begin
        checks++;
        if (strobe_prev) begin
          errors++; $display("FAIL strobe_width: strobe high 2 cycles at cyc %0d, required 1", cyc);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL strobe_unexpected: addr=%0d, required no access", c_addr);
        end else if (c_addr !== exp_q[0].addr || c_wr !== exp_q[0].wr ||
                     (exp_q[0].wr && c_wd !== exp_q[0].wdata)) begin
          errors++;
          $display("FAIL cache_fields: addr=%0d wr=%b wd=%h, required addr=%0d wr=%b wd=%h",
                   c_addr, c_wr, c_wd, exp_q[0].addr, exp_q[0].wr, exp_q[0].wdata);
        end
      end
      strobe_prev = c_strobe;
      if (ack_a || ack_b) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL ack_unexpected: AckA=%b AckB=%b at cyc %0d", ack_a, ack_b, cyc);
        end else begin
          e = exp_q.pop_front();
          $display("txn port=%s wr=%b addr=%0d ack_cyc=%0d rdata=%h", ack_b ? "B" : "A",
                   e.wr, e.addr, cyc, rdata);
          if (ack_b !== e.port) begin
            errors++; $display("FAIL ack_port: got AckB=%b, required port %0d", ack_b, e.port);
          end
          checks++;
          if (cyc != e.cyc) begin
            errors++; $display("FAIL ack_cycle: got %0d, required %0d (addr %0d)", cyc, e.cyc, e.addr);
          end
          if (!e.wr) begin
            checks++;
            if (rdata !== e.rdata) begin
              errors++; $display("FAIL rdata: got %h, required %h (addr %0d)", rdata, e.rdata, e.addr);
            end
          end
        end
      end
    end else begin
      strobe_prev = 1'b0;
    end
  end

  task automatic wait_done(input int n);
    int got = 0;
    for (int i = 0; i < 80 && got < n; i++) begin
      @(negedge clk);
      if (ack_a) begin req_a = 1'b0; got++; end
      if (ack_b) begin req_b = 1'b0; got++; end
    end
    checks++;
    if (got < n) begin
      errors++; $display("FAIL ack_timeout: got %0d acks, required %0d", got, n);
      req_a = 1'b0; req_b = 1'b0;
      exp_q.delete();
    end
  endtask

  task automatic drive(input logic port, input logic wr, input logic [15:0] a, input logic [15:0] wd);
    if (port) begin req_b = 1'b1; wr_b = wr; addr_b = a; wd_b = wd; end
    else      begin req_a = 1'b1; wr_a = wr; addr_a = a; wd_a = wd; end
  endtask

  task automatic run_single(input logic port, input logic wr, input logic [15:0] a, input logic [15:0] wd);
    int k, t;
    @(posedge clk); #1;
    k = cyc;
    drive(port, wr, a, wd);
    t = push_exp(port, wr, a, wd, k);
    wait_done(1);
  endtask

  task automatic run_dual(input logic wa, input logic [15:0] aa, input logic [15:0] da,
                          input logic wb, input logic [15:0] ab, input logic [15:0] db);
    int k, t;
    @(posedge clk); #1;
    k = cyc;
    drive(1'b0, wa, aa, da);
    drive(1'b1, wb, ab, db);
    if (m_last) begin
      t = push_exp(1'b0, wa, aa, da, k);
      t = push_exp(1'b1, wb, ab, db, t + 1);
    end else begin
      t = push_exp(1'b1, wb, ab, db, k);
      t = push_exp(1'b0, wa, aa, da, t + 1);
    end
    wait_done(2);
  endtask

  task automatic check_reset_outputs(input string tag);
    logic [83:0] v;
    v = {ack_a, ack_b, c_strobe, c_wr, c_addr, c_wd, rdata, hit_cnt, miss_cnt};
    checks++;
    if (v !== '0) begin
      errors++; $display("FAIL %s: outputs=%h, required all zero", tag, v);
    end
  endtask

  task automatic check_stats(input string tag);
    int eh, em;
`ifdef CACHE_ARBITER_STATS_EN
    eh = m_hits; em = m_misses;
`else
    eh = 0; em = 0;
`endif
    checks++;
    if (int'(hit_cnt) != eh || int'(miss_cnt) != em) begin
      errors++; $display("FAIL %s: hits=%0d misses=%0d, required %0d/%0d", tag, hit_cnt, miss_cnt, eh, em);
    end
  endtask

  task automatic z_run(input logic wr);
    int k, got;
    @(posedge clk); #1;
    k = cyc; got = 0;
    z_req = 1'b1; z_wr = wr; z_addr = 16'd28; z_wd = 16'h0077;
    for (int i = 0; i < 20 && got == 0; i++) begin
      @(negedge clk);
      if (z_ack_a) begin
        got = 1; z_req = 1'b0;
        $display("txn zlat wr=%b addr=28 ack_cyc=%0d rdata=%h", wr, cyc, z_rdata);
        checks++;
        if (cyc != k + 3) begin
          errors++; $display("FAIL zlat_cycle: got %0d, required %0d", cyc, k + 3);
        end
        if (!wr) begin
          checks++;
          if (z_rdata !== 16'hBEEF) begin
            errors++; $display("FAIL zlat_rdata: got %h, required beef", z_rdata);
          end
        end
      end
    end
    checks++;
    if (got == 0) begin
      errors++; $display("FAIL zlat_timeout: no AckA within 20 cycles");
      z_req = 1'b0;
    end
  endtask

  task automatic reset_in_stall();
    int t;
    logic [15:0] d;
    @(posedge clk); #1;
    d = 16'($urandom);
    drive(1'b0, 1'b1, 16'd12, d);
    t = push_exp(1'b0, 1'b1, 16'd12, d, cyc);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_in_stall");
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    req_a = 1'b0;
    m_hits = 0; m_misses = 0; m_last = 1'b1; m_last_ack = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_stats("stats_after_reset");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    req_a = 0; req_b = 0; wr_a = 0; wr_b = 0;
    addr_a = 0; addr_b = 0; wd_a = 0; wd_b = 0;
    z_req = 0; z_wr = 0; z_zero = 0; z_addr = 0; z_wd = 0; z_zero16 = 0;
    z_hit = 0; z_crd = 16'hBEEF;
    c_hit = 0; c_rd = 0;
    for (int a = 0; a < 32; a++) begin
      s_mem[a] = 16'h1000 + 16'(a * 7);
      m_mem[a] = 16'h1000 + 16'(a * 7);
    end
    for (int i = 0; i < 8; i++) begin
      s_tag[i]  = 13'd0;
      s_data[i] = s_mem[i];
      m_res[i]  = i;
    end
    m_hits = 0; m_misses = 0; m_last = 1'b1; m_last_ack = 0;

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    run_single(1'b0, 1'b0, 16'd5, 16'd0);
    run_single(1'b0, 1'b1, 16'd9, 16'd19);
    run_single(1'b0, 1'b0, 16'd9, 16'd0);
    run_dual(1'b0, 16'd3, 16'd0, 1'b0, 16'd4, 16'd0);
    run_dual(1'b1, 16'd6, 16'h00AA, 1'b0, 16'd20, 16'd0);
    run_single(1'b0, 1'b0, 16'd28, 16'd0);
    check_stats("stats_directed");

    z_run(1'b0);
    z_run(1'b1);

    reset_in_stall();
    run_single(1'b1, 1'b0, 16'd12, 16'd0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        run_dual(1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 16'($urandom),
                 1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 16'($urandom));
      end else begin
        run_single(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   16'($urandom_range(0, 31)), 16'($urandom));
      end
    end

    repeat (2) @(negedge clk);
    check_stats("stats_final");
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
